// File: rtl/pe_ws_dbuf.sv
// -----------------------------------------------------------------------------
// pe_ws_dbuf
//   Weight-stationary systolic MAC processing element with a double-buffered
//   weight. It has two weight registers:
//     * shadow: loaded through a column shift chain while compute continues.
//     * active: used by the MAC. A swap token copies shadow into active.
//   The swap token travels east one PE per cycle, so it moves with the
//   activation wavefront.
//   Operand and accumulator widths are configurable, and the datapath can be
//   signed (two's complement) or unsigned.
//
// Optional build macro:
//   PE_SAT_EN  When defined, the MAC sum saturates and o_ovf is a sticky
//              saturation flag. When undefined, the sum wraps modulo 2^ACC_W
//              and o_ovf is tied to 0.
//
// Parameters:
//   DATA_W    activation width (west/east)
//   WEIGHT_W  weight width
//   ACC_W     partial-sum width (north/south); must be >= DATA_W+WEIGHT_W
//   SIGNED    1 = two's-complement arithmetic, 0 = unsigned
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-high reset
//   i_wload        shadow-weight shift enable (broadcast down the column)
//   i_weight       shadow weight from the PE above / column feeder
//   o_weight       current shadow value, drives i_weight of the PE below
//   i_swap         swap token from west
//   o_swap         registered swap token to east
//   i_west         activation from west
//   i_west_valid   activation valid
//   o_east         registered activation to east
//   o_east_valid   registered activation valid
//   i_north        partial sum from north
//   i_north_valid  partial-sum valid (top row ties to 0)
//   o_south        registered partial sum to south
//   o_south_valid  registered partial-sum valid
//   o_ovf          sticky saturation flag (PE_SAT_EN builds only)
// -----------------------------------------------------------------------------
module pe_ws_dbuf #(
  parameter int DATA_W   = 8,
  parameter int WEIGHT_W = 8,
  parameter int ACC_W    = 32,
  parameter bit SIGNED   = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_wload,
  input  logic [WEIGHT_W-1:0] i_weight,
  output logic [WEIGHT_W-1:0] o_weight,
  input  logic                i_swap,
  output logic                o_swap,
  input  logic [DATA_W-1:0]   i_west,
  input  logic                i_west_valid,
  output logic [DATA_W-1:0]   o_east,
  output logic                o_east_valid,
  input  logic [ACC_W-1:0]    i_north,
  input  logic                i_north_valid,
  output logic [ACC_W-1:0]    o_south,
  output logic                o_south_valid,
  output logic                o_ovf
);

  localparam int PROD_W = DATA_W + WEIGHT_W;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [WEIGHT_W-1:0] shadow_reg;
  logic [WEIGHT_W-1:0] active_reg;
  logic                swap_reg;
  logic [DATA_W-1:0]   east_reg;
  logic                east_valid_reg;
  logic [ACC_W-1:0]    south_reg;
  logic                south_valid_reg;

  logic [ACC_W-1:0]    south_next;
  logic                south_valid_next;

  // ---------------------------------------------------------------------------
  // Weight double buffer.
  // If a swap and a load happen in the same cycle, both use the value the
  // shadow register held before the edge: active takes the old shadow, and
  // shadow takes i_weight.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_reg <= '0;
      active_reg <= '0;
      swap_reg   <= 1'b0;
    end else begin
      if (i_wload) begin
        shadow_reg <= i_weight;
      end
      if (i_swap) begin
        active_reg <= shadow_reg;
      end
      swap_reg <= i_swap;
    end
  end

  // ---------------------------------------------------------------------------
  // Activation forwarding: one cycle of latency, independent of the weights.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      east_reg       <= '0;
      east_valid_reg <= 1'b0;
    end else begin
      east_reg       <= i_west;
      east_valid_reg <= i_west_valid;
    end
  end

  // ---------------------------------------------------------------------------
  // Multiplier. The product is extended to ACC_W according to SIGNED.
  // ---------------------------------------------------------------------------
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] addend;

  generate
    if (SIGNED) begin : g_mul_signed
      logic signed [PROD_W-1:0] prod_s;
      // Widen both operands as signed values before multiplying so the full
      // two's-complement product is kept.
      assign prod_s   = PROD_W'($signed(active_reg)) * PROD_W'($signed(i_west));
      assign prod_ext = ACC_W'(prod_s);
    end else begin : g_mul_unsigned
      logic [PROD_W-1:0] prod_u;
      assign prod_u   = PROD_W'(active_reg) * PROD_W'(i_west);
      assign prod_ext = ACC_W'(prod_u);
    end
  endgenerate

  // An invalid north input adds nothing, so the top row needs no special case.
  assign addend = i_north_valid ? i_north : '0;

  // ---------------------------------------------------------------------------
  // Accumulate: either wrapping, or saturating with overflow detection.
  // ---------------------------------------------------------------------------
  logic [ACC_W-1:0] mac_sum;

`ifdef PE_SAT_EN
  logic [ACC_W:0]   sum_ext;
  logic             sat_hit;
  logic [ACC_W-1:0] sat_val;
  logic             ovf_reg;

  generate
    if (SIGNED) begin : g_sat_signed
      // Add with one guard bit. The result overflowed when the guard bit and
      // the top result bit disagree. The guard bit also gives the direction
      // of the clamp.
      assign sum_ext = {prod_ext[ACC_W-1], prod_ext} + {addend[ACC_W-1], addend};
      assign sat_hit = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];
      assign sat_val = sum_ext[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                      : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin : g_sat_unsigned
      // An unsigned add can only overflow upward, which shows as a carry out.
      assign sum_ext = {1'b0, prod_ext} + {1'b0, addend};
      assign sat_hit = sum_ext[ACC_W];
      assign sat_val = '1;
    end
  endgenerate

  assign mac_sum = sat_hit ? sat_val : sum_ext[ACC_W-1:0];

  // The flag only counts clamps from a real MAC cycle. Pass-through cycles
  // never clamp.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_reg <= 1'b0;
    end else if (i_west_valid && sat_hit) begin
      ovf_reg <= 1'b1;
    end
  end

  assign o_ovf = ovf_reg;
`else
  assign mac_sum = prod_ext + addend;
  assign o_ovf   = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Partial-sum path.
  //   valid activation -> MAC result
  //   only north valid -> pass i_north through unchanged
  //   neither valid    -> hold the data, drop the valid
  // ---------------------------------------------------------------------------
  always_comb begin
    south_next       = south_reg;
    south_valid_next = 1'b0;
    if (i_west_valid) begin
      south_next       = mac_sum;
      south_valid_next = 1'b1;
    end else if (i_north_valid) begin
      south_next       = i_north;
      south_valid_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      south_reg       <= '0;
      south_valid_reg <= 1'b0;
    end else begin
      south_reg       <= south_next;
      south_valid_reg <= south_valid_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. o_weight comes straight from the shadow register, so a column
  // chain advances one row per load pulse.
  // ---------------------------------------------------------------------------
  assign o_weight      = shadow_reg;
  assign o_swap        = swap_reg;
  assign o_east        = east_reg;
  assign o_east_valid  = east_valid_reg;
  assign o_south       = south_reg;
  assign o_south_valid = south_valid_reg;

endmodule

// File: tb/tb_pe_ws_dbuf.sv
module tb_pe_ws_dbuf;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- 3-PE column chain (default 8/8/32 signed) ----------------
  logic        c_wload, c_swap, c_wv, c_nv;
  logic [7:0]  c_feed, c_west;
  logic [31:0] c_north;
  logic [7:0]  c_wout   [0:2];
  logic        c_swpo   [0:2];
  logic [7:0]  c_east   [0:2];
  logic        c_ev     [0:2];
  logic [31:0] c_south  [0:2];
  logic        c_sv     [0:2];
  logic        c_ovf    [0:2];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chain
      pe_ws_dbuf u_pe (
        .clk(clk), .reset(reset),
        .i_wload(c_wload),
        .i_weight((gi == 0) ? c_feed : c_wout[(gi == 0) ? 0 : gi - 1]),
        .o_weight(c_wout[gi]),
        .i_swap(c_swap), .o_swap(c_swpo[gi]),
        .i_west(c_west), .i_west_valid(c_wv),
        .o_east(c_east[gi]), .o_east_valid(c_ev[gi]),
        .i_north(c_north), .i_north_valid(c_nv),
        .o_south(c_south[gi]), .o_south_valid(c_sv[gi]),
        .o_ovf(c_ovf[gi])
      );
    end
  endgenerate

  // ---------------- ACC_W=16 signed PE and 32-bit unsigned PE ----------------
  logic        x_wload, x_swap, x_wv, x_nv;
  logic [7:0]  x_weight, x_west;
  logic [31:0] x_north;

  logic [7:0]  a_wout, a_east;
  logic        a_swpo, a_ev, a_sv, a_ovf;
  logic [15:0] a_south;

  logic [7:0]  b_wout, b_east;
  logic        b_swpo, b_ev, b_sv, b_ovf;
  logic [31:0] b_south;

  pe_ws_dbuf #(.DATA_W(8), .WEIGHT_W(8), .ACC_W(16), .SIGNED(1'b1)) u_acc16 (
    .clk(clk), .reset(reset),
    .i_wload(x_wload), .i_weight(x_weight), .o_weight(a_wout),
    .i_swap(x_swap), .o_swap(a_swpo),
    .i_west(x_west), .i_west_valid(x_wv),
    .o_east(a_east), .o_east_valid(a_ev),
    .i_north(x_north[15:0]), .i_north_valid(x_nv),
    .o_south(a_south), .o_south_valid(a_sv),
    .o_ovf(a_ovf)
  );

  pe_ws_dbuf #(.DATA_W(8), .WEIGHT_W(8), .ACC_W(32), .SIGNED(1'b0)) u_uns (
    .clk(clk), .reset(reset),
    .i_wload(x_wload), .i_weight(x_weight), .o_weight(b_wout),
    .i_swap(x_swap), .o_swap(b_swpo),
    .i_west(x_west), .i_west_valid(x_wv),
    .o_east(b_east), .o_east_valid(b_ev),
    .i_north(x_north), .i_north_valid(x_nv),
    .o_south(b_south), .o_south_valid(b_sv),
    .o_ovf(b_ovf)
  );

  // ---------------- vector table for chain PE 0 ----------------
  typedef struct {
    logic        wload;
    logic [7:0]  weight;
    logic        swap;
    logic [7:0]  west;
    logic        wv;
    logic [31:0] north;
    logic        nv;
    logic [31:0] e_south;
    logic        e_sv;
    logic [7:0]  e_east;
    logic        e_ev;
    logic        e_swap;
    logic [7:0]  e_weight;
  } vec_t;

  vec_t vecs [11];

`ifdef PE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  initial begin
    //          wl  weight  sw west   wv north          nv  e_south        e_sv e_east e_ev e_sw e_weight
    vecs[0]  = '{1, 8'hFD, 0, 8'h00, 0, 32'd0,        0, 32'd0,        0, 8'h00, 0, 0, 8'hFD}; // load -3
    vecs[1]  = '{0, 8'h00, 1, 8'h00, 0, 32'd0,        0, 32'd0,        0, 8'h00, 0, 1, 8'hFD}; // swap
    vecs[2]  = '{0, 8'h00, 0, 8'h05, 1, 32'd100,      1, 32'd85,       1, 8'h05, 1, 0, 8'hFD}; // -3*5+100
    vecs[3]  = '{1, 8'h04, 0, 8'h00, 0, 32'd0,        0, 32'd85,       0, 8'h00, 0, 0, 8'h04}; // shadow=4, hold
    vecs[4]  = '{1, 8'h06, 1, 8'h00, 0, 32'd0,        0, 32'd85,       0, 8'h00, 0, 1, 8'h06}; // swap+load
    vecs[5]  = '{0, 8'h00, 0, 8'h02, 1, 32'd0,        0, 32'd8,        1, 8'h02, 1, 0, 8'h06}; // 4*2
    vecs[6]  = '{0, 8'h00, 0, 8'hFF, 1, 32'd100,      1, 32'd96,       1, 8'hFF, 1, 0, 8'h06}; // 4*-1+100
    vecs[7]  = '{0, 8'h00, 0, 8'h00, 0, 32'd1234,     1, 32'd1234,     1, 8'h00, 0, 0, 8'h06}; // pass-through
    vecs[8]  = '{0, 8'h00, 0, 8'h00, 0, 32'd0,        0, 32'd1234,     0, 8'h00, 0, 0, 8'h06}; // hold
    vecs[9]  = '{0, 8'h00, 0, 8'h80, 1, 32'hFFFFFFFB, 1, 32'hFFFFFDFB, 1, 8'h80, 1, 0, 8'h06}; // 4*-128-5
    vecs[10] = '{0, 8'h00, 0, 8'h03, 1, 32'd999,      0, 32'd12,       1, 8'h03, 1, 0, 8'h06}; // north ignored

    reset = 1'b1;
    c_wload = 0; c_swap = 0; c_wv = 0; c_nv = 0; c_feed = '0; c_west = '0; c_north = '0;
    x_wload = 0; x_swap = 0; x_wv = 0; x_nv = 0; x_weight = '0; x_west = '0; x_north = '0;

    // Reset state (async, before any clock edge)
    #3;
    check("rst_south",  c_south[0], 32'd0);
    check("rst_sv",     {31'd0, c_sv[0]}, 32'd0);
    check("rst_east_v", {31'd0, c_ev[0]}, 32'd0);
    check("rst_weight", {24'd0, c_wout[0]}, 32'd0);
    check("rst_ovf16",  {31'd0, a_ovf}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Table-driven vectors on chain PE 0
    for (int i = 0; i < 11; i++) begin
      c_wload = vecs[i].wload; c_feed = vecs[i].weight; c_swap = vecs[i].swap;
      c_west  = vecs[i].west;  c_wv   = vecs[i].wv;
      c_north = vecs[i].north; c_nv   = vecs[i].nv;
      step();
      check($sformatf("v%0d_south", i),  c_south[0], vecs[i].e_south);
      check($sformatf("v%0d_sv", i),     {31'd0, c_sv[0]}, {31'd0, vecs[i].e_sv});
      check($sformatf("v%0d_east", i),   {24'd0, c_east[0]}, {24'd0, vecs[i].e_east});
      check($sformatf("v%0d_ev", i),     {31'd0, c_ev[0]}, {31'd0, vecs[i].e_ev});
      check($sformatf("v%0d_swap", i),   {31'd0, c_swpo[0]}, {31'd0, vecs[i].e_swap});
      check($sformatf("v%0d_weight", i), {24'd0, c_wout[0]}, {24'd0, vecs[i].e_weight});
      check($sformatf("v%0d_ovf", i),    {31'd0, c_ovf[0]}, 32'd0);
      $display("vec %0d south=%0h sv=%0b east=%0h", i, c_south[0], c_sv[0], c_east[0]);
    end

    // Column chain: feed 7,8,9 then swap everywhere
    c_wv = 0; c_nv = 0; c_swap = 0; c_wload = 1;
    c_feed = 8'd7; step();
    c_feed = 8'd8; step();
    c_feed = 8'd9; step();
    c_wload = 0;
    check("chain_bottom_weight", {24'd0, c_wout[2]}, 32'd7);
    check("chain_top_weight",    {24'd0, c_wout[0]}, 32'd9);
    c_swap = 1; step();
    c_swap = 0; c_west = 8'd1; c_wv = 1; c_north = 32'd500; c_nv = 0;
    step();
    check("chain_active0", c_south[0], 32'd9);
    check("chain_active1", c_south[1], 32'd8);
    check("chain_active2", c_south[2], 32'd7);
    $display("chain active weights %0d %0d %0d", c_south[0], c_south[1], c_south[2]);
    c_wv = 0;

    // ACC_W=16 overflow case: 127*127 + 20000 = 36129
    x_wload = 1; x_weight = 8'd127; step();
    x_wload = 0; x_swap = 1; step();
    x_swap = 0; x_west = 8'd127; x_wv = 1; x_north = 32'd20000; x_nv = 1;
    step();
    check("acc16_south", {16'd0, a_south}, SAT ? 32'h7FFF : 32'h8D21);
    check("acc16_ovf",   {31'd0, a_ovf}, {31'd0, SAT});
    $display("acc16 south=%0h ovf=%0b", a_south, a_ovf);
    x_west = 8'd0; x_north = 32'd0;
    step();
    check("acc16_zero", {16'd0, a_south}, 32'd0);
    check("acc16_sticky", {31'd0, a_ovf}, {31'd0, SAT});
    x_wv = 0; x_nv = 0;

    // Unsigned: 200*250 + 1 = 50001
    x_wload = 1; x_weight = 8'd200; step();
    x_wload = 0; x_swap = 1; step();
    x_swap = 0; x_west = 8'd250; x_wv = 1; x_north = 32'd1; x_nv = 1;
    step();
    check("uns_south", b_south, 32'd50001);
    check("uns_sv", {31'd0, b_sv}, 32'd1);
    $display("unsigned south=%0d", b_south);

    // Reset mid-cycle: outputs clear before the next edge
    #3 reset = 1'b1;
    #1;
    check("mid_rst_south", b_south, 32'd0);
    check("mid_rst_sv",    {31'd0, b_sv}, 32'd0);
    check("mid_rst_east",  {24'd0, b_east}, 32'd0);
    check("mid_rst_ev",    {31'd0, b_ev}, 32'd0);
    check("mid_rst_weight", {24'd0, b_wout}, 32'd0);
    check("mid_rst_ovf16", {31'd0, a_ovf}, 32'd0);
    $display("mid-cycle reset south=%0h east=%0h", b_south, b_east);
    #1 reset = 1'b0;
    x_west = 8'd1; x_wv = 1; x_nv = 0;
    step();
    check("post_rst_active", b_south, 32'd0);
    check("post_rst_sv", {31'd0, b_sv}, 32'd1);
    $display("post-reset MAC south=%0d", b_south);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_ws_dbuf.md
Name: pe_ws_dbuf

Overview:
Parametrised weight-stationary processing element for the systolic MAC array. It generalises the int8 PE with configurable operand and accumulator widths and a signed/unsigned mode. It adds a double-buffered weight: a shadow register loaded via a column shift chain while compute continues, swapped into the active register by a swap token that travels east with the data wavefront. It also adds valid qualifiers on both data paths and optional saturating accumulation.

Parameters:
DATA_W, 8, width of west/east activation operand
WEIGHT_W, 8, width of weight operand
ACC_W, 32, width of north/south partial sum; must be >= DATA_W+WEIGHT_W
SIGNED, 1, 1 = two's-complement operands and partial sums; 0 = unsigned

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous active-high reset
i_wload  input  1  column-broadcast shadow-weight shift enable
i_weight  input  WEIGHT_W  shadow weight in from PE above (or column feeder)
o_weight  output  WEIGHT_W  shadow register value, drives i_weight of PE below
i_swap  input  1  swap token from west
o_swap  output  1  registered swap token to east
i_west  input  DATA_W  activation from west
i_west_valid  input  1  activation valid
o_east  output  DATA_W  registered activation to east
o_east_valid  output  1  registered activation valid
i_north  input  ACC_W  partial sum from north
i_north_valid  input  1  partial sum valid; top row ties to 0
o_south  output  ACC_W  registered partial sum to south
o_south_valid  output  1  registered partial sum valid
o_ovf  output  1  sticky saturation flag (PE_SAT_EN only)

Behaviour:
- Reset (async, immediate): shadow, active weight, o_east, o_east_valid, o_swap, o_south, o_south_valid, o_ovf all 0. Deasserts synchronously to the design; the first update is the first rising edge after release.
- Shadow chain: if i_wload, shadow <= i_weight; else hold. o_weight = shadow directly, with no extra flop. N wload pulses on a column place the first-fed weight in row N-1 (bottom) and the last-fed in row 0.
- Swap: o_swap <= i_swap every cycle (1-cycle forward). If i_swap, active <= shadow.
- Simultaneous i_swap and i_wload: active takes the pre-edge shadow value; shadow takes i_weight.
- Activation path, every cycle: o_east <= i_west; o_east_valid <= i_west_valid. Latency 1, independent of weights.
- MAC: product = active * i_west, extended to ACC_W (sign-extended if SIGNED, else zero). addend = i_north if i_north_valid, else 0.
- If i_west_valid: o_south <= product + addend; o_south_valid <= 1.
- If !i_west_valid: o_south holds its value; o_south_valid <= i_north_valid and, if i_north_valid, o_south <= i_north (pass-through).
- MAC uses the active weight as of the pre-edge value. A swap in the same cycle affects the next activation only.
- Sum wraps modulo 2^ACC_W unless PE_SAT_EN.
- No stall input; the array controller gates the valids.

Optional Feature:
PE_SAT_EN: when defined, the MAC sum saturates. SIGNED=1 clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; SIGNED=0 clamps to 2^ACC_W-1. Any clamp sets o_ovf, which stays set until reset. When not defined, the sum wraps and o_ovf is tied 0.

Test Plan:
- Signed MAC: wload weight=-3, swap, west=5 valid, north=100 valid -> next cycle o_south=85, o_south_valid=1, o_east=5, o_east_valid=1.
- Chain of 3 PEs: 3 wload cycles feeding 7,8,9, then swap on all -> active weights top-to-bottom 9,8,7; o_weight of bottom PE = 7.
- Swap+wload same cycle: shadow=4, load 6 with swap -> active=4, shadow=6; next west=2 with north invalid -> o_south=8.
- Pass-through: west invalid, north=1234 valid -> o_south=1234 valid. Then both invalid -> o_south holds 1234, o_south_valid=0.
- ACC_W=16 signed: weight=127, west=127, north=20000 -> with PE_SAT_EN o_south=32767 and o_ovf=1 (sticky). Without it, o_south=-29407 and o_ovf=0.
- SIGNED=0: weight=200, west=250, north=1 -> 50001. Assert reset mid-cycle -> all outputs 0 before the next edge, and active weight=0 after release.
